// File: rtl/module_uart_rx.sv
// rtl/module_uart_rx.sv - memory-mapped 8N1 UART receiver with mid-bit sampling and a small receive FIFO
module module_uart_rx #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  input  logic        we_proc_i,
  input  logic        re_proc_i,
  input  logic [31:0] addr_proc_i,
  input  logic [31:0] do_proc_i,
  output logic [31:0] do_proc_o,
  output logic        rx_avail_o
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = 4;
  localparam logic [TW-1:0] T_HALF   = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t          state, state_nx;
  logic [TW-1:0]   timer, timer_nx;
  logic [2:0]      bit_idx, bit_idx_nx;
  logic [7:0]      shift, shift_nx;
  logic            push_req, frame_bad;

  logic            rx_meta, rxs;
  logic            enable, overrun, frame_err;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  logic            ctrl_wr, pop, push, full, not_empty, set_overrun;
  logic [7:0]      head;
  logic            unused_bits;

  assign unused_bits = ^{addr_proc_i[31:3], addr_proc_i[1:0], do_proc_i[31:4], do_proc_i[1]};

  assign ctrl_wr     = we_proc_i & ~addr_proc_i[2];
  assign not_empty   = (count != '0);
  assign full        = (count == FULL_CNT);
  assign pop         = re_proc_i & addr_proc_i[2] & not_empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO still succeeds.
  assign push        = push_req & (~full | pop);
  assign set_overrun = push_req & full & ~pop;

  always_comb begin
    state_nx   = state;
    timer_nx   = timer;
    bit_idx_nx = bit_idx;
    shift_nx   = shift;
    push_req   = 1'b0;
    frame_bad  = 1'b0;
    if (!enable) begin
      state_nx = S_IDLE;
      timer_nx = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state_nx = S_START;
            timer_nx = '0;
          end
        end
        S_START: begin
          if (timer == T_HALF) begin
            timer_nx   = '0;
            bit_idx_nx = '0;
            state_nx   = rxs ? S_IDLE : S_DATA;
          end else begin
            timer_nx = timer + 1'b1;
          end
        end
        S_DATA: begin
          if (timer == T_LAST) begin
            shift_nx   = {rxs, shift[7:1]};
            timer_nx   = '0;
            bit_idx_nx = bit_idx + 1'b1;
            if (bit_idx == 3'd7) state_nx = S_STOP;
          end else begin
            timer_nx = timer + 1'b1;
          end
        end
        S_STOP: begin
          if (timer == T_LAST) begin
            timer_nx = '0;
            if (rxs) begin
              push_req = 1'b1;
              state_nx = S_IDLE;
            end else begin
              frame_bad = 1'b1;
              state_nx  = S_WAIT_HIGH;
            end
          end else begin
            timer_nx = timer + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (rxs) state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta   <= 1'b1;
      rxs       <= 1'b1;
      state     <= S_IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      enable    <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      rx_meta <= rx_i;
      rxs     <= rx_meta;
      state   <= state_nx;
      timer   <= timer_nx;
      bit_idx <= bit_idx_nx;
      shift   <= shift_nx;
      if (ctrl_wr) enable <= do_proc_i[0];
      // Hardware set wins over a software clear in the same cycle.
      if (set_overrun)                   overrun <= 1'b1;
      else if (ctrl_wr && do_proc_i[2])  overrun <= 1'b0;
      if (frame_bad)                     frame_err <= 1'b1;
      else if (ctrl_wr && do_proc_i[3])  frame_err <= 1'b0;
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= shift;
  end

  assign head       = not_empty ? mem[rd_ptr] : 8'h00;
  assign rx_avail_o = not_empty;
  assign do_proc_o  = addr_proc_i[2] ? {24'b0, head}
                                     : {25'b0, count[2:0], frame_err, overrun, not_empty, enable};

endmodule

// File: tb/tb_module_uart_rx.sv
// tb/tb_module_uart_rx.sv - directed self-checking bench for module_uart_rx
module tb_module_uart_rx;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rx_avail;

  int n_checks = 0;
  int n_errors = 0;

  module_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rx_i       (rx),
    .we_proc_i  (we),
    .re_proc_i  (re),
    .addr_proc_i(addr),
    .do_proc_i  (wdata),
    .do_proc_o  (rdata),
    .rx_avail_o (rx_avail)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic expect_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic pop();
    @(negedge clk);
    addr = 32'h4; re = 1'b1;
    @(negedge clk);
    re = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0)      rx = 1'b0;
      else if (i <= 8) rx = b[i-1];
      else             rx = stop;
      repeat (CPB - 1) @(negedge clk);
    end
  endtask

  initial begin
    int   lat;
    logic found;

    idle(3);
    rst = 1'b0;
    expect_reg("reset_ctrl", 32'h0, 32'h0);
    expect_reg("reset_data", 32'h4, 32'h0);
    check("reset_avail", {31'b0, rx_avail}, 32'h0);

    // Single byte with latency measurement from the start-bit falling edge.
    bus_write(32'h0, 32'h1);
    expect_reg("enable_ctrl", 32'h0, 32'h01);
    found = 1'b0;
    lat   = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int k = 0; k < 170 && !found; k++) begin
          @(negedge clk);
          if (rx_avail) begin
            found = 1'b1;
            lat   = k;
          end
        end
      end
    join
    check("latency_found", {31'b0, found}, 32'h1);
    check("latency_range", {31'b0, (lat >= 150 && lat <= 156)}, 32'h1);
    expect_reg("a5_ctrl", 32'h0, 32'h13);
    expect_reg("a5_data", 32'h4, 32'hA5);
    pop();
    expect_reg("a5_pop_ctrl", 32'h0, 32'h01);
    expect_reg("a5_pop_data", 32'h4, 32'h00);

    // Short low pulse must be rejected at the start-bit check.
    @(negedge clk);
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(30);
    expect_reg("glitch_ctrl", 32'h0, 32'h01);
    check("glitch_avail", {31'b0, rx_avail}, 32'h0);

    // Framing error followed by a break, then a good frame.
    send_frame(8'h3C, 1'b0);
    idle(40);
    rx = 1'b1;
    idle(10);
    expect_reg("ferr_ctrl", 32'h0, 32'h09);
    send_frame(8'h7E, 1'b1);
    idle(10);
    expect_reg("ferr_7e_ctrl", 32'h0, 32'h1B);
    expect_reg("ferr_7e_data", 32'h4, 32'h7E);
    bus_write(32'h0, 32'h9);
    expect_reg("ferr_clear", 32'h0, 32'h13);
    pop();
    expect_reg("ferr_pop", 32'h0, 32'h01);

    // Overrun: five bytes into a four-entry FIFO.
    for (int v = 1; v <= 5; v++) begin
      send_frame(8'(v), 1'b1);
      idle(4);
    end
    expect_reg("ovr_ctrl", 32'h0, 32'h47);
    for (int v = 1; v <= 4; v++) begin
      expect_reg($sformatf("ovr_data%0d", v), 32'h4, 32'(v));
      pop();
    end
    expect_reg("ovr_empty", 32'h0, 32'h05);
    bus_write(32'h0, 32'h5);
    expect_reg("ovr_clear", 32'h0, 32'h01);
    send_frame(8'h06, 1'b1);
    idle(4);
    send_frame(8'h07, 1'b1);
    idle(4);
    expect_reg("wrap_06", 32'h4, 32'h06);
    pop();
    expect_reg("wrap_07", 32'h4, 32'h07);
    pop();
    expect_reg("wrap_empty", 32'h0, 32'h01);

    // Pop on the exact stop-sample edge while full.
    send_frame(8'h11, 1'b1); idle(4);
    send_frame(8'h22, 1'b1); idle(4);
    send_frame(8'h33, 1'b1); idle(4);
    send_frame(8'h44, 1'b1); idle(4);
    expect_reg("full_ctrl", 32'h0, 32'h43);
    fork
      send_frame(8'h55, 1'b1);
      begin
        repeat (155) @(negedge clk);
        addr = 32'h4; re = 1'b1;
        @(negedge clk);
        re = 1'b0;
      end
    join
    idle(4);
    expect_reg("simul_ctrl", 32'h0, 32'h43);
    expect_reg("simul_22", 32'h4, 32'h22);
    pop();
    expect_reg("simul_33", 32'h4, 32'h33);
    pop();
    expect_reg("simul_44", 32'h4, 32'h44);
    pop();
    expect_reg("simul_55", 32'h4, 32'h55);
    pop();
    expect_reg("simul_empty", 32'h0, 32'h01);

    // Disable during the data bits of 0xF0.
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (60) @(negedge clk);
        we = 1'b1; addr = 32'h0; wdata = 32'h0;
        @(negedge clk);
        we = 1'b0;
      end
    join
    idle(10);
    expect_reg("dis_ctrl", 32'h0, 32'h00);
    check("dis_avail", {31'b0, rx_avail}, 32'h0);
    bus_write(32'h0, 32'h1);
    send_frame(8'h0F, 1'b1);
    idle(4);
    expect_reg("reen_ctrl", 32'h0, 32'h13);
    expect_reg("reen_data", 32'h4, 32'h0F);
    pop();

    // Empty pop and data-register write have no effect.
    pop();
    bus_write(32'h4, 32'hFF);
    expect_reg("empty_pop_ctrl", 32'h0, 32'h01);
    expect_reg("empty_pop_data", 32'h4, 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
